// File: rtl/win_scanner_if.sv
// Handshake and result bundle between the board register file, the line-win
// scanner and the game-control FSM.
interface win_scanner_if #(
   parameter int N = 3
) ();
   localparam int C  = N * N;
   localparam int LW = $clog2(2 * N + 2);

   logic          start;
   logic [C-1:0]  val;
   logic [C-1:0]  sym;
   logic          busy;
   logic          done;
   logic [1:0]    gs;
   logic          draw;
   logic [LW-1:0] win_line;

   modport master (
      output start, val, sym,
      input  busy, done, gs, draw, win_line
   );

   modport slave (
      input  start, val, sym,
      output busy, done, gs, draw, win_line
   );
endinterface

// File: rtl/win_scanner.sv
// Sequential N x N line-win checker: latches a board on start, evaluates one
// line per clock (rows, columns, two diagonals) and reports the winner.
module win_scanner #(
   parameter int N = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   win_scanner_if.slave  bus
);
   localparam int C  = N * N;
   localparam int L  = 2 * N + 2;
   localparam int LW = $clog2(L);
   localparam int CW = $clog2(C);
   localparam logic [LW-1:0] LAST = LW'(L - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state_q, state_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [C-1:0]  val_q, val_d;
   logic [C-1:0]  sym_q, sym_d;
   logic          accx_q, accx_d;
   logic          acco_q, acco_d;
   logic          found_q, found_d;
   logic [LW-1:0] first_q, first_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    gs_q, gs_d;
   logic          draw_q, draw_d;
   logic [LW-1:0] win_line_q, win_line_d;
   logic [1:0]    hit;

   // Cell index of the k-th cell on a given line.
   function automatic logic [CW-1:0] cell_of(input logic [LW-1:0] line, input int k);
      int li;
      int ci;
      li = int'(line);
      if (li < N)           ci = li * N + k;
      else if (li < 2 * N)  ci = (li - N) + k * N;
      else if (li == 2 * N) ci = k * N + k;
      else                  ci = k * N + N - 1 - k;
      return CW'(ci);
   endfunction

   // {O wins, X wins} for one line of the latched board.
   function automatic logic [1:0] line_hit(input logic [C-1:0] v, input logic [C-1:0] s,
                                           input logic [LW-1:0] line);
      logic          all_x;
      logic          all_o;
      logic [CW-1:0] c;
      all_x = 1'b1;
      all_o = 1'b1;
      for (int k = 0; k < N; k++) begin
         c     = cell_of(line, k);
         all_x = all_x & v[c] & s[c];
         all_o = all_o & v[c] & ~s[c];
      end
      return {all_o, all_x};
   endfunction

   assign hit = line_hit(val_q, sym_q, idx_q);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      val_d      = val_q;
      sym_d      = sym_q;
      accx_d     = accx_q;
      acco_d     = acco_q;
      found_d    = found_q;
      first_d    = first_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      gs_d       = gs_q;
      draw_d     = draw_q;
      win_line_d = win_line_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               val_d   = bus.val;
               sym_d   = bus.sym;
               accx_d  = 1'b0;
               acco_d  = 1'b0;
               found_d = 1'b0;
               first_d = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            accx_d = accx_q | hit[0];
            acco_d = acco_q | hit[1];
            if ((hit != 2'b00) && !found_q) begin
               found_d = 1'b1;
               first_d = idx_q;
            end
            // No early exit: a board with lines for both players must report 11.
            if (idx_q == LAST) begin
               gs_d       = {acco_d, accx_d};
               draw_d     = (&val_q) & ~(accx_d | acco_d);
               win_line_d = first_d;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         val_q      <= '0;
         sym_q      <= '0;
         accx_q     <= 1'b0;
         acco_q     <= 1'b0;
         found_q    <= 1'b0;
         first_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         gs_q       <= 2'b00;
         draw_q     <= 1'b0;
         win_line_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         val_q      <= val_d;
         sym_q      <= sym_d;
         accx_q     <= accx_d;
         acco_q     <= acco_d;
         found_q    <= found_d;
         first_q    <= first_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         gs_q       <= gs_d;
         draw_q     <= draw_d;
         win_line_q <= win_line_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.gs       = gs_q;
   assign bus.draw     = draw_q;
   assign bus.win_line = win_line_q;
endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner: one N=3 and one N=4 instance driven with
// hand-worked boards, latency, reset and start-handling cases.
module tb_win_scanner;
   logic clk;
   logic rst_n;

   int n_chk;
   int n_pass;
   logic [1:0] last_gs [2];

   win_scanner_if #(.N(3)) if3 ();
   win_scanner_if #(.N(4)) if4 ();

   win_scanner #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
   win_scanner #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_start(input bit big, input logic b);
      if (big) if4.start = b;
      else     if3.start = b;
   endtask

   task automatic set_board(input bit big, input logic [15:0] v, input logic [15:0] s);
      if (big) begin
         if4.val = v;
         if4.sym = s;
      end else begin
         if3.val = v[8:0];
         if3.sym = s[8:0];
      end
   endtask

   function automatic logic [31:0] get_busy(input bit big);
      return big ? 32'(if4.busy) : 32'(if3.busy);
   endfunction
   function automatic logic [31:0] get_done(input bit big);
      return big ? 32'(if4.done) : 32'(if3.done);
   endfunction
   function automatic logic [31:0] get_gs(input bit big);
      return big ? 32'(if4.gs) : 32'(if3.gs);
   endfunction
   function automatic logic [31:0] get_draw(input bit big);
      return big ? 32'(if4.draw) : 32'(if3.draw);
   endfunction
   function automatic logic [31:0] get_wl(input bit big);
      return big ? 32'(if4.win_line) : 32'(if3.win_line);
   endfunction

   // Called just after a rising edge; start is sampled at the next edge (E0).
   task automatic scan(input string tag, input bit big, input logic [15:0] v, input logic [15:0] s,
                       input logic [1:0] exp_gs, input logic exp_draw, input int exp_wl,
                       input int restart_at, input int alt_at,
                       input logic [15:0] alt_v, input logic [15:0] alt_s);
      int lat;
      int lim;
      bit seen;
      lim = big ? 10 : 8;
      set_board(big, v, s);
      set_start(big, 1'b1);
      @(posedge clk); #1;
      set_start(big, 1'b0);
      check({tag, "_busy_e0"}, get_busy(big), 1);
      check({tag, "_gs_hold"}, get_gs(big), 32'(last_gs[big]));
      lat  = -1;
      seen = 1'b0;
      for (int c = 1; c <= 30 && !seen; c++) begin
         set_start(big, (c == restart_at) ? 1'b1 : 1'b0);
         if (c == alt_at) set_board(big, alt_v, alt_s);
         @(posedge clk); #1;
         if (get_done(big) == 1) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      set_start(big, 1'b0);
      check({tag, "_latency"}, lat, lim);
      check({tag, "_gs"}, get_gs(big), 32'(exp_gs));
      check({tag, "_draw"}, get_draw(big), 32'(exp_draw));
      check({tag, "_win_line"}, get_wl(big), exp_wl);
      check({tag, "_busy_done"}, get_busy(big), 0);
      @(posedge clk); #1;
      check({tag, "_done_1cyc"}, get_done(big), 0);
      check({tag, "_gs_keep"}, get_gs(big), 32'(exp_gs));
      last_gs[big] = exp_gs;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int ndone;
      int t1;
      int t2;
      n_chk = 0;
      n_pass = 0;
      last_gs[0] = 2'b00;
      last_gs[1] = 2'b00;
      rst_n = 1'b0;
      if3.start = 1'b1;
      if4.start = 1'b1;
      if3.val = 9'($urandom);
      if3.sym = 9'($urandom);
      if4.val = 16'($urandom);
      if4.sym = 16'($urandom);

      // Reset held with arbitrary inputs.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy3", 32'(if3.busy), 0);
      check("rst_done3", 32'(if3.done), 0);
      check("rst_gs3", 32'(if3.gs), 0);
      check("rst_draw3", 32'(if3.draw), 0);
      check("rst_wl3", 32'(if3.win_line), 0);
      check("rst_busy4", 32'(if4.busy), 0);
      check("rst_gs4", 32'(if4.gs), 0);
      check("rst_wl4", 32'(if4.win_line), 0);
      if3.start = 1'b0;
      if4.start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;

      scan("x_row0", 1'b0, 16'h0007, 16'h0007, 2'b01, 1'b0, 0, 0, 0, 0, 0);
      scan("o_anti", 1'b0, 16'h0054, 16'h0000, 2'b10, 1'b0, 7, 0, 0, 0, 0);
      // XXO / OOX / XOX: full board, no line.
      scan("draw3", 1'b0, 16'h01FF, 16'h0163, 2'b00, 1'b1, 0, 0, 0, 0, 0);
      scan("both3", 1'b0, 16'h01C7, 16'h0007, 2'b11, 1'b0, 0, 3, 0, 0, 0);

      // Reset asserted in the middle of a scan.
      set_board(1'b0, 16'h0007, 16'h0007);
      set_start(1'b0, 1'b1);
      @(posedge clk); #1;
      set_start(1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(if3.busy), 0);
      check("midrst_done", 32'(if3.done), 0);
      check("midrst_gs", 32'(if3.gs), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (if3.done) ndone++;
      end
      check("midrst_nodone", ndone, 0);
      last_gs[0] = 2'b00;
      last_gs[1] = 2'b00;

      scan("o_col2", 1'b1, 16'h4444, 16'h0000, 2'b10, 1'b0, 6, 0, 0, 0, 0);
      // Row 1 missing one cell; inputs switched to a winning board mid-scan.
      scan("row1_gap", 1'b1, 16'h00E0, 16'h00E0, 2'b00, 1'b0, 0, 0, 4, 16'hF0F0, 16'hFFFF);

      // Start held high: second scan accepted in the done cycle.
      set_board(1'b1, 16'h8421, 16'h8421);
      set_start(1'b1, 1'b1);
      ndone = 0;
      t1 = -1;
      t2 = -1;
      for (int c = 0; c <= 30 && ndone < 2; c++) begin
         @(posedge clk); #1;
         if (if4.done) begin
            ndone++;
            if (ndone == 1) t1 = c;
            else t2 = c;
         end
      end
      set_start(1'b1, 1'b0);
      check("held_first", t1, 10);
      check("held_gap", t2 - t1, 11);
      check("diag_gs", 32'(if4.gs), 32'h1);
      check("diag_wl", 32'(if4.win_line), 8);
      repeat (14) @(posedge clk);
      #1;
      check("held_idle", 32'(if4.busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
